// File: rtl/product_accumulator_if.sv
// Handshake bundle between a product source, the accumulator and the sum consumer.
// Parameters must match the product_accumulator instance it is connected to.
interface product_accumulator_if #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int CW = 4
);
  logic          start;
  logic [CW-1:0] len;
  logic [PW-1:0] p_in;
  logic          p_valid;
  logic          p_ready;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;
  logic          busy;
  logic          ovf;

  modport master (
    output start, len, p_in, p_valid, sum_ready,
    input  p_ready, sum_out, sum_valid, busy, ovf
  );

  modport slave (
    input  start, len, p_in, p_valid, sum_ready,
    output p_ready, sum_out, sum_valid, busy, ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a burst of LEN unsigned products and hands the total downstream.
// Build option: define PRODUCT_ACC_SAT_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int PW = 8,
  parameter int AW = 12,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state, nxt;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [CW-1:0] cnt;
  logic          ovf_r;
  logic          xfer;
  logic [AW:0]   sum_ext;

  assign xfer    = (state == ACCUM) && bus.p_valid;
  // One spare bit catches the carry-out that drives ovf.
  assign sum_ext = {1'b0, acc} + {{(AW+1-PW){1'b0}}, bus.p_in};

`ifdef PRODUCT_ACC_SAT_EN
  assign acc_nxt = sum_ext[AW] ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
  assign acc_nxt = sum_ext[AW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = (bus.len != '0) ? ACCUM : DONE;
      ACCUM:   if (xfer && cnt == CW'(1)) nxt = DONE;
      DONE:    if (bus.sum_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.p_ready   = (state == ACCUM);
    bus.sum_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.sum_out   = acc;
    bus.ovf       = ovf_r;
  end

  // acc only moves on a start or a transfer, so it is frozen while DONE waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc   <= '0;
      cnt   <= bus.len;
      ovf_r <= 1'b0;
    end else if (xfer) begin
      acc   <= acc_nxt;
      cnt   <= cnt - CW'(1);
      ovf_r <= ovf_r | sum_ext[AW];
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: table-driven bursts plus hand sequences.
// A second instance with AW=10 exercises overflow (wrap, or clamp with PRODUCT_ACC_SAT_EN).
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_accumulator_if #(.PW(8), .AW(12), .CW(4)) a();
  product_accumulator_if #(.PW(8), .AW(10), .CW(4)) b();

  product_accumulator #(.PW(8), .AW(12), .CW(4)) dut   (.clk(clk), .rst(rst), .bus(a));
  product_accumulator #(.PW(8), .AW(10), .CW(4)) dut10 (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    logic [11:0] sum;
    logic        ovf;
  } exp_t;

  typedef struct {
    int               len;
    logic [15:0][7:0] p;
    int               gap;
    logic [11:0]      sum;
    logic             ovf;
  } vec_t;

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic [11:0] OVF_SUM = 12'd1023;
`else
  localparam logic [11:0] OVF_SUM = 12'd101;
`endif

  exp_t q12[$];
  exp_t q10[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboards: pop one expectation per sum handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a.sum_valid && a.sum_ready) begin
      if (q12.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb12_unexpected: got sum %0d expected none", a.sum_out);
      end else begin
        e = q12.pop_front();
        check("sb12_sum", 32'(a.sum_out), 32'(e.sum));
        check("sb12_ovf", 32'(a.ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b.sum_valid && b.sum_ready) begin
      if (q10.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb10_unexpected: got sum %0d expected none", b.sum_out);
      end else begin
        e = q10.pop_front();
        check("sb10_sum", 32'(b.sum_out), 32'(e.sum));
        check("sb10_ovf", 32'(b.ovf), 32'(e.ovf));
      end
    end
  end

  task automatic start_burst(input int l);
    @(posedge clk); #1;
    a.start = 1'b1;
    a.len   = 4'(l);
    @(posedge clk); #1;
    a.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    int k;
    repeat (gap) begin
      a.p_valid = 1'b0;
      @(posedge clk); #1;
    end
    a.p_valid = 1'b1;
    a.p_in    = v;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a.p_ready) break;
      @(posedge clk); #1;
    end
    if (k == 20) begin
      n_cmp++; n_bad++;
      $display("FAIL p_ready_timeout: got p_ready 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    a.p_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!a.busy) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL idle_timeout_a: got busy 1 expected 0");
  endtask

  task automatic wait_idle_b();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!b.busy) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL idle_timeout_b: got busy 1 expected 0");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a.start = 1'b0; a.len = '0; a.p_in = '0; a.p_valid = 1'b0; a.sum_ready = 1'b1;
    b.start = 1'b0; b.len = '0; b.p_in = '0; b.p_valid = 1'b0; b.sum_ready = 1'b1;

    tbl[0].len = 3; tbl[0].p = '0; tbl[0].gap = 0; tbl[0].sum = 12'd245; tbl[0].ovf = 1'b0;
    tbl[0].p[0] = 8'd5; tbl[0].p[1] = 8'd15; tbl[0].p[2] = 8'd225;
    tbl[1].len = 1; tbl[1].p = '0; tbl[1].gap = 0; tbl[1].sum = 12'd255; tbl[1].ovf = 1'b0;
    tbl[1].p[0] = 8'd255;
    tbl[2].len = 2; tbl[2].p = '0; tbl[2].gap = 4; tbl[2].sum = 12'd90; tbl[2].ovf = 1'b0;
    tbl[2].p[0] = 8'd10; tbl[2].p[1] = 8'd80;
    tbl[3].len = 4; tbl[3].p = '0; tbl[3].gap = 0; tbl[3].sum = 12'd0; tbl[3].ovf = 1'b0;
    tbl[4].len = 15; tbl[4].gap = 0; tbl[4].sum = 12'd3825; tbl[4].ovf = 1'b0;
    for (int i = 0; i < 16; i++) tbl[4].p[i] = 8'd255;
    tbl[5].len = 6; tbl[5].p = '0; tbl[5].gap = 1; tbl[5].sum = 12'd21; tbl[5].ovf = 1'b0;
    for (int i = 0; i < 6; i++) tbl[5].p[i] = 8'(i + 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_p_ready",   32'(a.p_ready),   0);
    check("rst_sum_valid", 32'(a.sum_valid), 0);
    check("rst_busy",      32'(a.busy),      0);
    check("rst_ovf",       32'(a.ovf),       0);
    check("rst_sum_out",   32'(a.sum_out),   0);
    rst = 1'b0;

    // Table bursts, sum_ready held high.
    for (int v = 0; v < 6; v++) begin
      q12.push_back('{sum: tbl[v].sum, ovf: tbl[v].ovf});
      start_burst(tbl[v].len);
      for (int i = 0; i < tbl[v].len; i++) send(tbl[v].p[i], (i == 0) ? 0 : tbl[v].gap);
      @(negedge clk);
      check("lat_sum_valid", 32'(a.sum_valid), 1);
      check("lat_p_ready",   32'(a.p_ready),   0);
      wait_idle_a();
    end

    // Gaps plus 3 cycles of backpressure.
    a.sum_ready = 1'b0;
    q12.push_back('{sum: 12'd90, ovf: 1'b0});
    start_burst(2);
    send(8'd10, 0);
    send(8'd80, 4);
    repeat (3) begin
      @(negedge clk);
      check("bp_sum_valid", 32'(a.sum_valid), 1);
      check("bp_sum_out",   32'(a.sum_out),   90);
      @(posedge clk); #1;
    end
    a.sum_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_busy",      32'(a.busy),      0);
    check("bp_idle_sum_valid", 32'(a.sum_valid), 0);

    // Zero-length burst.
    q12.push_back('{sum: 12'd0, ovf: 1'b0});
    @(posedge clk); #1;
    a.start = 1'b1; a.len = 4'd0;
    @(negedge clk);
    check("zl_p_ready0", 32'(a.p_ready), 0);
    @(posedge clk); #1;
    a.start = 1'b0;
    @(negedge clk);
    check("zl_p_ready1",  32'(a.p_ready),   0);
    check("zl_sum_valid", 32'(a.sum_valid), 1);
    check("zl_sum_out",   32'(a.sum_out),   0);
    wait_idle_a();

    // Reset mid-burst after 2 of 4 transfers.
    start_burst(4);
    send(8'd100, 0);
    send(8'd50, 0);
    rst = 1'b1;
    #1;
    check("mrst_p_ready",   32'(a.p_ready),   0);
    check("mrst_sum_valid", 32'(a.sum_valid), 0);
    check("mrst_busy",      32'(a.busy),      0);
    check("mrst_ovf",       32'(a.ovf),       0);
    check("mrst_sum_out",   32'(a.sum_out),   0);
    #2;
    rst = 1'b0;
    q12.push_back('{sum: 12'd7, ovf: 1'b0});
    start_burst(2);
    send(8'd3, 0);
    send(8'd4, 0);
    wait_idle_a();

    // start with len=9 held through ACCUM and DONE must be ignored.
    q12.push_back('{sum: 12'd30, ovf: 1'b0});
    start_burst(2);
    a.start = 1'b1; a.len = 4'd9;
    send(8'd10, 0);
    a.sum_ready = 1'b0;
    send(8'd20, 0);
    @(negedge clk);
    check("ign_sum_valid0", 32'(a.sum_valid), 1);
    check("ign_p_ready",    32'(a.p_ready),   0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ign_sum_valid1", 32'(a.sum_valid), 1);
    check("ign_sum_out",    32'(a.sum_out),   30);
    @(posedge clk); #1;
    a.sum_ready = 1'b1;
    @(posedge clk); #1;
    a.start = 1'b0;
    @(negedge clk);
    check("ign_busy", 32'(a.busy), 0);

    // Overflow on the AW=10 instance: 5 x 225 = 1125.
    q10.push_back('{sum: OVF_SUM, ovf: 1'b1});
    @(posedge clk); #1;
    b.start = 1'b1; b.len = 4'd5;
    @(posedge clk); #1;
    b.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b.p_valid = 1'b1; b.p_in = 8'd225;
      @(posedge clk); #1;
      if (i == 3) check("ovf_before", 32'(b.ovf), 0);
    end
    b.p_valid = 1'b0;
    @(negedge clk);
    check("ovf_flag",  32'(b.ovf),     1);
    check("ovf_sum",   32'(b.sum_out), 32'(OVF_SUM));
    wait_idle_b();

    // Next start clears the sticky flag.
    q10.push_back('{sum: 12'd7, ovf: 1'b0});
    @(posedge clk); #1;
    b.start = 1'b1; b.len = 4'd1;
    @(posedge clk); #1;
    b.start = 1'b0;
    b.p_valid = 1'b1; b.p_in = 8'd7;
    @(posedge clk); #1;
    b.p_valid = 1'b0;
    wait_idle_b();

    repeat (3) @(posedge clk);
    #1;
    check("q12_drained", 32'(q12.size()), 0);
    check("q10_drained", 32'(q10.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
